// File: rtl/interface_name_pkg_hdl.sv
// Shared types and default widths for the interface_name HDL-side monitor capture path.
// The record struct matches the default widths; parameterised instances pack the same field order.
package interface_name_pkg_hdl;

  localparam int CAP_ADDR_W = 32;
  localparam int CAP_DATA_W = 32;
  localparam int CAP_BEAT_W = 8;
  localparam int CAP_SEQ_W  = 16;
  localparam int CAP_DEPTH  = 8;

  typedef struct packed {
    logic [CAP_ADDR_W-1:0] addr;
    logic [CAP_BEAT_W-1:0] beats;
    logic [CAP_DATA_W-1:0] xor_data;
    logic [CAP_SEQ_W-1:0]  seq;
  } interface_name_cap_rec_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_COLLECT
  } cap_state_e;

endpackage

// File: rtl/interface_name_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head word reads as zero while empty.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module interface_name_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty masks stale contents and resetting RAM costs logic.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/interface_name_mon_capture.sv
// Monitor capture stage: assembles valid/ready beats into transaction records and queues them
// for the HVL proxy; records that find the queue full are dropped and counted.
module interface_name_mon_capture
  import interface_name_pkg_hdl::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DATA_W = CAP_DATA_W,
  parameter int BEAT_W = CAP_BEAT_W,
  parameter int SEQ_W  = CAP_SEQ_W,
  parameter int DEPTH  = CAP_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mon_valid,
  input  logic                     mon_ready,
  input  logic [ADDR_W-1:0]        mon_addr,
  input  logic [DATA_W-1:0]        mon_data,
  input  logic                     mon_last,
  output logic                     txn_valid,
  input  logic                     txn_ready,
  output logic [ADDR_W-1:0]        txn_addr,
  output logic [BEAT_W-1:0]        txn_beats,
  output logic [DATA_W-1:0]        txn_xor,
  output logic [SEQ_W-1:0]         txn_seq,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              drop_count,
  output logic                     overflow
);

  localparam int REC_W = ADDR_W + BEAT_W + DATA_W + SEQ_W;

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [BEAT_W-1:0] beats_q, cur_beats;
  logic [DATA_W-1:0] xor_q, cur_xor;
  logic [SEQ_W-1:0]  seq_ctr;
  logic [REC_W-1:0]  fifo_din, fifo_dout;
  logic              beat, commit, pop, push, drop, full, empty;

  assign beat   = mon_valid & mon_ready & enable;
  assign commit = beat & mon_last;
  assign pop    = txn_valid & txn_ready;
  assign push   = commit & (~full | pop);
  assign drop   = commit & full & ~pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cur_addr  = addr_q;
    cur_beats = beats_q;
    cur_xor   = xor_q;
    case (state_q)
      CAP_IDLE: begin
        if (beat) begin
          cur_addr  = mon_addr;
          cur_beats = BEAT_W'(1);
          cur_xor   = mon_data;
          state_d   = mon_last ? CAP_IDLE : CAP_COLLECT;
        end
      end
      CAP_COLLECT: begin
        if (beat) begin
          if (beats_q != '1) cur_beats = beats_q + 1'b1;
          cur_xor = xor_q ^ mon_data;
          if (mon_last) state_d = CAP_IDLE;
        end
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CAP_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      xor_q   <= '0;
    end else begin
      state_q <= state_d;
      if (beat) begin
        addr_q  <= cur_addr;
        beats_q <= cur_beats;
        xor_q   <= cur_xor;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_ctr    <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // Sequence advances on drops too, so consumers can see gaps.
      if (commit) seq_ctr <= seq_ctr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign fifo_din = {cur_addr, cur_beats, cur_xor, seq_ctr};

  interface_name_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign txn_valid = ~empty;
  assign {txn_addr, txn_beats, txn_xor, txn_seq} = fifo_dout;

endmodule

// File: tb/tb_interface_name_mon_capture.sv
// Self-checking bench: queue-based transaction model compared every cycle, plus directed literal checks.
module tb_interface_name_mon_capture;
  import interface_name_pkg_hdl::*;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mon_valid = 1'b0;
  logic        mon_ready = 1'b0;
  logic [31:0] mon_addr = '0;
  logic [31:0] mon_data = '0;
  logic        mon_last = 1'b0;
  logic        txn_valid;
  logic        txn_ready = 1'b0;
  logic [31:0] txn_addr;
  logic [7:0]  txn_beats;
  logic [31:0] txn_xor;
  logic [15:0] txn_seq;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  interface_name_mon_capture dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mon_valid  (mon_valid),
    .mon_ready  (mon_ready),
    .mon_addr   (mon_addr),
    .mon_data   (mon_data),
    .mon_last   (mon_last),
    .txn_valid  (txn_valid),
    .txn_ready  (txn_ready),
    .txn_addr   (txn_addr),
    .txn_beats  (txn_beats),
    .txn_xor    (txn_xor),
    .txn_seq    (txn_seq),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: completed records in a queue, current transfer as a list of beat data.
  interface_name_cap_rec_t mq[$];
  logic [31:0]             part[$];
  logic [31:0]             p_addr;
  int                      m_seq, m_drop;
  bit                      m_ovf;
  interface_name_cap_rec_t nrec;
  logic [31:0]             acc;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      part.delete();
      m_seq  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (mq.size() > 0 && txn_ready) void'(mq.pop_front());
      if (mon_valid && mon_ready && enable) begin
        if (part.size() == 0) p_addr = mon_addr;
        part.push_back(mon_data);
        if (mon_last) begin
          acc = '0;
          foreach (part[i]) acc ^= part[i];
          nrec.addr     = p_addr;
          nrec.beats    = (part.size() > 255) ? 8'd255 : 8'(part.size());
          nrec.xor_data = acc;
          nrec.seq      = 16'(m_seq);
          m_seq         = (m_seq + 1) % 65536;
          part.delete();
          if (mq.size() < DEPTH) mq.push_back(nrec);
          else begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("valid", txn_valid, mq.size() != 0);
      check("level", fifo_level, mq.size());
      check("drops", drop_count, m_drop);
      check("ovf", overflow, m_ovf);
      if (mq.size() != 0) begin
        check("addr", txn_addr, mq[0].addr);
        check("beats", txn_beats, mq[0].beats);
        check("xor", txn_xor, mq[0].xor_data);
        check("seq", txn_seq, mq[0].seq);
      end
    end
  end

  task automatic step(input bit v, input bit e, input logic [31:0] a, input logic [31:0] d,
                      input bit l);
    mon_valid = v;
    mon_ready = v;
    enable    = e;
    mon_addr  = a;
    mon_data  = d;
    mon_last  = l;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 1, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    txn_ready = 1'b1;
    while (mq.size() != 0 && n < 40) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    check("drain_bound", mq.size(), 0);
    txn_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_valid", txn_valid, 0);
    check("rst_level", fifo_level, 0);

    // Single beat, visible the cycle after commit.
    step(1, 1, 32'h100, 32'hA5A5_0000, 1);
    check("t1_valid", txn_valid, 1);
    check("t1_addr", txn_addr, 32'h100);
    check("t1_beats", txn_beats, 1);
    check("t1_xor", txn_xor, 32'hA5A5_0000);
    check("t1_seq", txn_seq, 0);
    drain();

    // Four-beat transfer; only the first address counts.
    do_reset();
    step(1, 1, 32'h40, 1, 0);
    step(1, 1, 32'h44, 2, 0);
    step(1, 1, 32'h48, 4, 0);
    step(1, 1, 32'h4C, 8, 1);
    check("t2_addr", txn_addr, 32'h40);
    check("t2_beats", txn_beats, 4);
    check("t2_xor", txn_xor, 32'hF);
    check("t2_seq", txn_seq, 0);
    drain();

    // Overflow: ten commits into an eight-deep FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 32'(i), 32'(i * 3), 1);
    step(0, 1, 0, 0, 0);
    check("t3_level", fifo_level, 8);
    check("t3_drops", drop_count, 2);
    check("t3_ovf", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check("t3_seq_order", txn_seq, i);
      txn_ready = 1'b1;
      step(0, 1, 0, 0, 0);
    end
    txn_ready = 1'b0;
    step(1, 1, 32'h77, 32'h1, 1);
    check("t3_seq_gap", txn_seq, 10);

    // Full FIFO with commit and pop in the same cycle.
    for (int i = 0; i < 7; i++) step(1, 1, 32'(i), 32'(i), 1);
    check("t4_full", fifo_level, 8);
    txn_ready = 1'b1;
    step(1, 1, 32'h99, 32'h5, 1);
    txn_ready = 1'b0;
    check("t4_level", fifo_level, 8);
    check("t4_drops", drop_count, 2);
    check("t4_head", txn_seq, 11);
    drain();

    // Reset mid-transfer, reset beats a coincident last beat.
    step(1, 1, 32'h300, 1, 0);
    step(1, 1, 32'h304, 2, 0);
    reset = 1'b1;
    step(1, 1, 32'h308, 4, 1);
    reset = 1'b0;
    step(0, 1, 0, 0, 0);
    check("t6_valid", txn_valid, 0);
    check("t6_addr", txn_addr, 0);
    check("t6_beats", txn_beats, 0);
    check("t6_xor", txn_xor, 0);
    check("t6_seq", txn_seq, 0);
    check("t6_drops", drop_count, 0);
    check("t6_ovf", overflow, 0);
    step(1, 1, 32'h500, 32'h1234, 1);
    check("t6_beats1", txn_beats, 1);
    check("t6_seq0", txn_seq, 0);
    check("t6_addr1", txn_addr, 32'h500);
    drain();

    // Enable low mid-transfer: held beats are ignored.
    step(1, 1, 32'h200, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h2FF, 32'hFF, 0);
    step(1, 1, 32'h204, 2, 0);
    step(1, 1, 32'h208, 4, 1);
    check("t5_beats", txn_beats, 3);
    check("t5_xor", txn_xor, 7);
    check("t5_addr", txn_addr, 32'h200);
    drain();

    // Beat-count saturation.
    for (int i = 0; i < 299; i++) step(1, 1, 32'h600 + 32'(i), 32'(i), 0);
    step(1, 1, 32'h0, 32'hDEAD, 1);
    check("sat_beats", txn_beats, 255);
    drain();

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 599) == 0);
      txn_ready = ($urandom_range(0, 2) == 0);
      mon_valid = ($urandom_range(0, 3) != 0);
      mon_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      mon_addr  = $urandom;
      mon_data  = $urandom;
      mon_last  = ($urandom_range(0, 3) == 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    mon_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
